// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory handshake, instruction-delivery port and redirect.
// master = fetch_queue, slave = core/memory side.
interface fetch_queue_if #(
  parameter int ADDR_W = 56,
  parameter int INST_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_valid;
  logic [INST_W-1:0] mem_data;
  logic              mem_err;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_fault;
  logic              inst_pop;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output mem_addr, mem_req, inst_valid, inst, inst_pc, inst_fault,
    input  mem_valid, mem_data, mem_err, inst_pop, redirect, redirect_pc
  );

  modport slave (
    input  mem_addr, mem_req, inst_valid, inst, inst_pc, inst_fault,
    output mem_valid, mem_data, mem_err, inst_pop, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch unit: fetches sequential words ahead of execution into a PC-tagged FIFO.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to the head of an empty queue.
module fetch_queue #(
  parameter int              ADDR_W   = 56,
  parameter int              DEPTH    = 4,
  parameter int              INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  phi1,
  input  logic                  rst,
  fetch_queue_if.master         bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // queue full, no request
    REQ     = 2'd1,  // request outstanding, response will be kept
    DISCARD = 2'd2,  // pre-redirect request outstanding, response will be dropped
    HALT    = 2'd3   // fault entry queued, fetch stopped until redirect
  } state_t;

  state_t state, state_next;

  logic [INST_W-1:0] data_q  [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic              fault_q [DEPTH];

  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count_next;
  logic [ADDR_W-1:0] fetch_pc, hold_pc;
  logic              accept, push, pop, head_valid, bypass;

  assign bus.mem_req  = !rst && (state == REQ || state == DISCARD);
  // While discarding, the old request's address must stay on the bus even though fetch_pc has moved on.
  assign bus.mem_addr = (state == DISCARD) ? hold_pc : fetch_pc;

  assign accept     = bus.mem_req && bus.mem_valid && (state == REQ) && !bus.redirect;
  assign head_valid = (count != '0);
  assign pop        = head_valid && bus.inst_pop && !bus.redirect && !rst;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = accept && !head_valid;
  assign push   = accept && !(bypass && bus.inst_pop);
`else
  assign bypass = 1'b0;
  assign push   = accept;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    bus.inst_valid = 1'b0;
    bus.inst       = '0;
    bus.inst_pc    = '0;
    bus.inst_fault = 1'b0;
    if (!rst) begin
      if (head_valid) begin
        bus.inst_valid = 1'b1;
        bus.inst       = data_q[rd_ptr];
        bus.inst_pc    = pc_q[rd_ptr];
        bus.inst_fault = fault_q[rd_ptr];
      end else if (bypass) begin
        bus.inst_valid = 1'b1;
        bus.inst       = bus.mem_data;
        bus.inst_pc    = fetch_pc;
        bus.inst_fault = bus.mem_err;
      end
    end
  end

  always_comb begin
    count_next = count;
    if (bus.redirect) begin
      count_next = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, REQ: begin
        if (bus.redirect)
          state_next = (state == REQ && !bus.mem_valid) ? DISCARD : REQ;
        else if (accept && bus.mem_err)
          state_next = HALT;
        else
          state_next = (count_next != FULL) ? REQ : IDLE;
      end
      // The queue was flushed on entry and nothing is pushed here, so it is empty on exit.
      DISCARD: if (bus.mem_valid) state_next = REQ;
      HALT:    if (bus.redirect)  state_next = REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge phi1) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RESET_PC;
      hold_pc  <= RESET_PC;
    end else begin
      state <= state_next;
      count <= count_next;
      if (bus.redirect) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
        if (state == REQ && !bus.mem_valid) hold_pc <= fetch_pc;
      end else begin
        if (push)   wr_ptr   <= wr_ptr + PTR_W'(1);
        if (pop)    rd_ptr   <= rd_ptr + PTR_W'(1);
        if (accept) fetch_pc <= fetch_pc + ADDR_W'(4);
      end
    end
  end

  // NOTE: entry storage has no reset; an entry is only visible once count covers it.
  always_ff @(posedge phi1) begin
    if (push) begin
      data_q[wr_ptr]  <= bus.mem_data;
      pc_q[wr_ptr]    <= fetch_pc;
      fault_q[wr_ptr] <= bus.mem_err;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: memory responder with random latency, scoreboard of the
// expected sequential instruction stream, directed scenarios followed by a randomized run.
module tb_fetch_queue;
  localparam int ADDR_W = 56;
  localparam int DEPTH  = 4;
  localparam int INST_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] data;
    logic              fault;
  } entry_t;

  logic phi1 = 1'b0;
  logic rst  = 1'b1;
  logic [$clog2(DEPTH):0] count;

  fetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  fetch_queue #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INST_W(INST_W), .RESET_PC(RESET_PC)
  ) dut (
    .phi1 (phi1),
    .rst  (rst),
    .bus  (bus),
    .count(count)
  );

  always #5 phi1 = ~phi1;

  int n_chk = 0;
  int n_err = 0;

  // Reference stream: after a reset or redirect to P the core must see P, P+4, ... up to and
  // including the first faulting word, each tagged with its memory contents.
  entry_t            exp_q[$];
  logic [ADDR_W-1:0] gen_pc = '0;
  bit                gen_done = 1'b0;
  bit                fault_en = 1'b0;
  logic [ADDR_W-1:0] fault_pc = '0;
  bit                rand_faults = 1'b0;

  // Memory responder state.
  int unsigned       lat_min = 0;
  int unsigned       lat_max = 0;
  int unsigned       lat_left = 0;
  bit                pending = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [INST_W-1:0] data_of(input logic [ADDR_W-1:0] a);
    return a[31:0] ^ {a[ADDR_W-1 -: 16], 16'h5A3C} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit fault_of(input logic [ADDR_W-1:0] a);
    return (fault_en && a == fault_pc) || (rand_faults && a[5:2] == 4'hB);
  endfunction

  task automatic model_refill();
    entry_t e;
    while (!gen_done && exp_q.size() < 16) begin
      e.pc    = gen_pc;
      e.data  = data_of(gen_pc);
      e.fault = fault_of(gen_pc);
      exp_q.push_back(e);
      if (e.fault) gen_done = 1'b1;
      gen_pc = gen_pc + ADDR_W'(4);
    end
  endtask

  task automatic model_restart(input logic [ADDR_W-1:0] pc);
    exp_q.delete();
    gen_pc   = {pc[ADDR_W-1:2], 2'b00};
    gen_done = 1'b0;
    model_refill();
  endtask

  // Applies one cycle of inputs at the falling edge, including the memory's reply.
  task automatic drive(input bit pop, input bit redir, input logic [ADDR_W-1:0] rpc);
    bus.inst_pop    = pop;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.mem_valid   = 1'b0;
    bus.mem_data    = '0;
    bus.mem_err     = 1'b0;
    if (rst) begin
      pending = 1'b0;
      model_restart(RESET_PC);
    end else begin
      if (pending) check("req_held", bus.mem_req == 1'b1, 64'(bus.mem_req), 64'd1);
      if (bus.mem_req) begin
        if (pending) begin
          check("req_addr_stable", bus.mem_addr == req_addr, 64'(bus.mem_addr), 64'(req_addr));
        end else begin
          pending  = 1'b1;
          req_addr = bus.mem_addr;
          lat_left = $urandom_range(lat_max, lat_min);
        end
        if (lat_left == 0) begin
          bus.mem_valid = 1'b1;
          bus.mem_data  = data_of(req_addr);
          bus.mem_err   = fault_of(req_addr);
          pending       = 1'b0;
        end else begin
          lat_left--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.mem_valid = 1'b1;
        bus.mem_data  = $urandom();
        bus.mem_err   = 1'($urandom_range(0, 1));
      end
      if (redir) model_restart(rpc);
      model_refill();
    end
  endtask

  task automatic tick(input bit pop, input bit redir, input logic [ADDR_W-1:0] rpc);
    @(negedge phi1);
    drive(pop, redir, rpc);
    @(posedge phi1);
    #1;
  endtask

  // Monitor: every instruction the core consumes must be the next one of the reference stream.
  entry_t mon_e;
  always @(negedge phi1) begin
    #1;
    if (!rst && bus.inst_valid && bus.inst_pop && !bus.redirect) begin
      check("pop_expected", exp_q.size() != 0, 64'(bus.inst_pc), 64'(gen_pc));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("pop_pc",    bus.inst_pc == mon_e.pc,       64'(bus.inst_pc),    64'(mon_e.pc));
        check("pop_inst",  bus.inst == mon_e.data,        64'(bus.inst),       64'(mon_e.data));
        check("pop_fault", bus.inst_fault == mon_e.fault, 64'(bus.inst_fault), 64'(mon_e.fault));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, n_chk=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] held;
    logic [ADDR_W-1:0] rpc;
    logic [63:0]       r64;
    bit                found;

    bus.inst_pop = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.mem_valid = 1'b0; bus.mem_data = '0; bus.mem_err = 1'b0;

    // Reset values.
    tick(0, 0, '0);
    tick(0, 0, '0);
    check("rst_count",      count == '0,           64'(count),          64'd0);
    check("rst_mem_req",    bus.mem_req == 1'b0,   64'(bus.mem_req),    64'd0);
    check("rst_inst_valid", bus.inst_valid == 1'b0, 64'(bus.inst_valid), 64'd0);
    check("rst_inst",       bus.inst == '0,        64'(bus.inst),       64'd0);
    check("rst_inst_pc",    bus.inst_pc == '0,     64'(bus.inst_pc),    64'd0);
    check("rst_inst_fault", bus.inst_fault == 1'b0, 64'(bus.inst_fault), 64'd0);

    // 1: memory answers every cycle, nothing consumed -> queue fills with 0,4,8,12.
    rst = 1'b0;
    tick(0, 0, '0);
    check("first_req",      bus.mem_req == 1'b1,   64'(bus.mem_req),  64'd1);
    check("first_addr",     bus.mem_addr == RESET_PC, 64'(bus.mem_addr), 64'(RESET_PC));
    tick(0, 0, '0);
    check("first_count",    count == 1,            64'(count),          64'd1);
    check("first_valid",    bus.inst_valid == 1'b1, 64'(bus.inst_valid), 64'd1);
    check("first_pc",       bus.inst_pc == '0,     64'(bus.inst_pc),    64'd0);
    for (int i = 0; i < 4; i++) tick(0, 0, '0);
    check("full_count",     count == 4,            64'(count),          64'd4);
    check("full_no_req",    bus.mem_req == 1'b0,   64'(bus.mem_req),    64'd0);

    // 2: one pop reopens fetch at 0x10; push and pop together keep the count.
    tick(1, 0, '0);
    check("refill_req",     bus.mem_req == 1'b1,   64'(bus.mem_req),    64'd1);
    check("refill_addr",    bus.mem_addr == 'h10,  64'(bus.mem_addr),   64'h10);
    tick(1, 0, '0);
    check("pushpop_count",  count == 3,            64'(count),          64'd3);
    for (int i = 0; i < 3; i++) tick(1, 0, '0);

    // 3: redirect while a slow request is outstanding; its response is dropped.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(0, 0, '0);
      found = pending;
    end
    check("pending_seen", found, 64'(found), 64'd1);
    held = bus.mem_addr;
    tick(0, 1, 'h1003);
    check("redir_count",    count == '0,           64'(count),          64'd0);
    check("redir_hold",     bus.mem_addr == held,  64'(bus.mem_addr),   64'(held));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(0, 0, '0);
      found = bus.mem_req && !pending && bus.mem_addr == 'h1000;
    end
    check("redir_new_addr", found, 64'(bus.mem_addr), 64'h1000);
    lat_min = 0; lat_max = 0;
    tick(0, 0, '0);
    check("redir_first_pc", bus.inst_valid && bus.inst_pc == 'h1000, 64'(bus.inst_pc), 64'h1000);
    for (int i = 0; i < 4; i++) tick(1, 0, '0);

    // 4: faulting response at pc 8 halts fetch until a redirect.
    fault_en = 1'b1; fault_pc = 'h8;
    tick(0, 1, '0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(0, 0, '0);
      found = !bus.mem_req && count == 3;
    end
    check("fault_halt",     found, 64'(count), 64'd3);
    check("fault_head_pc",  bus.inst_pc == '0,     64'(bus.inst_pc),    64'd0);
    for (int i = 0; i < 3; i++) tick(1, 0, '0);
    check("halt_empty",     count == '0,           64'(count),          64'd0);
    check("halt_no_req",    bus.mem_req == 1'b0,   64'(bus.mem_req),    64'd0);
    fault_en = 1'b0;
    tick(0, 1, 'h200);
    check("resume_req",     bus.mem_req == 1'b1,   64'(bus.mem_req),    64'd1);
    check("resume_addr",    bus.mem_addr == 'h200, 64'(bus.mem_addr),   64'h200);

    // 5: fetch across the top of the address space; steady push+pop holds the count.
    rpc = '1;
    rpc = rpc - ADDR_W'(6);
    tick(0, 1, rpc);
    tick(0, 0, '0);
    tick(0, 0, '0);
    check("wrap_fill",      count == 2,            64'(count),          64'd2);
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, '0);
      check("wrap_count",   count == 2,            64'(count),          64'd2);
    end

    // 6: response into an empty queue with a pop in the same cycle.
    lat_min = 2; lat_max = 2;
    tick(0, 1, 'h300);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge phi1);
      drive(1, 0, '0);
      #1;
      if (bus.mem_req && bus.mem_valid && bus.mem_addr == 'h300 && count == '0) begin
        found = 1'b1;
        check("latency_same_cycle", bus.inst_valid == BYPASS, 64'(bus.inst_valid), 64'(BYPASS));
      end
      @(posedge phi1);
      #1;
      if (found) check("latency_count", count == (BYPASS ? 0 : 1), 64'(count), BYPASS ? 64'd0 : 64'd1);
    end
    check("latency_seen", found, 64'(found), 64'd1);

    // Randomized run with random latency, pops, redirects, faults and the odd reset.
    rand_faults = 1'b1;
    lat_min = 0; lat_max = 3;
    tick(0, 1, 'h4000);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        tick(0, 0, '0);
        tick(0, 0, '0);
        check("rand_rst_count", count == '0,          64'(count),          64'd0);
        check("rand_rst_req",   bus.mem_req == 1'b0,  64'(bus.mem_req),    64'd0);
        check("rand_rst_valid", bus.inst_valid == 1'b0, 64'(bus.inst_valid), 64'd0);
        rst = 1'b0;
      end
      r64 = {$urandom(), $urandom()};
      rpc = ($urandom_range(0, 3) == 0) ? ('1 - ADDR_W'($urandom_range(0, 40))) : r64[ADDR_W-1:0];
      tick($urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0, rpc);
      check("count_range", count <= DEPTH, 64'(count), 64'(DEPTH));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
